// File: rtl/rbm_host_if_pkg.sv
// Shared configuration for rbm_host_if: FSM encodings, default dimensions,
// element packing macro and counter-width helper.
`ifndef RBM_HOST_IF_PKG_SV
`define RBM_HOST_IF_PKG_SV

// Element k of a packed vector whose elements are w bits wide.
`define RBM_ELEM(vec, k, w) vec[(k)*(w) +: (w)]

package rbm_host_if_pkg;

  localparam int RBM_BITLENGTH_DEF  = 12;
  localparam int RBM_INPUT_DIM_DEF  = 784;
  localparam int RBM_OUTPUT_DIM_DEF = 10;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rbm_state_e;

  function automatic int rbm_cnt_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

`endif

// File: rtl/rbm_argmax.sv
// Combinational argmax over the packed signed result vector; the lowest index
// wins on ties.
module rbm_argmax
  import rbm_host_if_pkg::*;
#(
  parameter int bitlength  = RBM_BITLENGTH_DEF,
  parameter int output_dim = RBM_OUTPUT_DIM_DEF
) (
  input  logic [output_dim*bitlength-1:0]    result,
  output logic [rbm_cnt_w(output_dim)-1:0]   argmax
);

  localparam int IDX_W = rbm_cnt_w(output_dim);

  logic [IDX_W-1:0]     best_idx_s;
  logic [bitlength-1:0] best_val_s;
  logic [bitlength-1:0] cand_s;

  // Linear scan; strict greater-than keeps the earliest maximum.
  always_comb begin
    best_idx_s = '0;
    best_val_s = `RBM_ELEM(result, 0, bitlength);
    cand_s     = '0;
    for (int k = 1; k < output_dim; k++) begin
      cand_s = `RBM_ELEM(result, k, bitlength);
      if ($signed(cand_s) > $signed(best_val_s)) begin
        best_val_s = cand_s;
        best_idx_s = IDX_W'(k);
      end else begin
        best_val_s = best_val_s;
        best_idx_s = best_idx_s;
      end
    end
  end

  assign argmax = best_idx_s;

endmodule

// File: rtl/rbm_host_if.sv
// Stream-to-vector host adapter for an RBM core: collects an image, holds it
// while the core runs, then streams the result. `RBM_ARGMAX_EN adds argmax ports.
module rbm_host_if
  import rbm_host_if_pkg::*;
#(
  parameter int bitlength  = RBM_BITLENGTH_DEF,
  parameter int input_dim  = RBM_INPUT_DIM_DEF,
  parameter int output_dim = RBM_OUTPUT_DIM_DEF
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [bitlength-1:0]             in_data,
  output logic                             in_ready,
  output logic                             data_valid,
  output logic [input_dim*bitlength-1:0]   InputDataPort,
  input  logic [output_dim*bitlength-1:0]  OutputDataPort,
  input  logic                             finish,
  output logic                             out_valid,
  output logic [bitlength-1:0]             out_data,
  output logic                             out_last,
  input  logic                             out_ready,
  output logic                             busy
`ifdef RBM_ARGMAX_EN
  ,
  output logic [rbm_cnt_w(output_dim)-1:0] argmax,
  output logic                             argmax_valid
`endif
);

  localparam int PIX_W = rbm_cnt_w(input_dim);
  localparam int OUT_W = rbm_cnt_w(output_dim);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(input_dim - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(output_dim - 1);

  rbm_state_e                     state_q, state_d;
  logic [PIX_W-1:0]               pix_cnt_q, pix_cnt_d;
  logic [OUT_W-1:0]               out_cnt_q, out_cnt_d;
  logic [input_dim*bitlength-1:0] img_q, img_d;
  logic [output_dim*bitlength-1:0] res_q, res_d;
  logic                           in_ready_q, in_ready_d;
  logic                           data_valid_q, data_valid_d;
  logic                           out_valid_q, out_valid_d;
  logic [bitlength-1:0]           out_data_q, out_data_d;
  logic                           out_last_q, out_last_d;
  logic                           busy_q, busy_d;
  logic                           in_hs_s, out_hs_s;

  // Next-state, counters, image/result capture and registered-output decode.
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    out_cnt_d = out_cnt_q;
    img_d     = img_q;
    res_d     = res_q;
    in_hs_s   = in_valid && in_ready_q;
    out_hs_s  = out_valid_q && out_ready;

    case (state_q)
      ST_LOAD: begin
        if (in_hs_s) begin
          `RBM_ELEM(img_d, pix_cnt_q, bitlength) = in_data;
          if (pix_cnt_q == PIX_LAST) begin
            pix_cnt_d = '0;
            state_d   = ST_RUN;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
        end else begin
          pix_cnt_d = pix_cnt_q;
        end
      end
      ST_RUN: begin
        if (finish) begin
          res_d     = OutputDataPort;
          out_cnt_d = '0;
          state_d   = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (out_hs_s) begin
          if (out_cnt_q == OUT_LAST) begin
            out_cnt_d = '0;
            state_d   = ST_LOAD;
          end else begin
            out_cnt_d = out_cnt_q + OUT_W'(1);
          end
        end else begin
          out_cnt_d = out_cnt_q;
        end
      end
      default: begin
        state_d   = ST_LOAD;
        pix_cnt_d = '0;
        out_cnt_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so they line up with it after the edge.
    in_ready_d   = (state_d == ST_LOAD);
    data_valid_d = (state_d == ST_RUN);
    out_valid_d  = (state_d == ST_DRAIN);
    busy_d       = (state_d != ST_LOAD);
    out_last_d   = out_valid_d && (out_cnt_d == OUT_LAST);
    if (out_valid_d) begin
      out_data_d = `RBM_ELEM(res_d, out_cnt_d, bitlength);
    end else begin
      out_data_d = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      pix_cnt_q    <= '0;
      out_cnt_q    <= '0;
      img_q        <= '0;
      res_q        <= '0;
      in_ready_q   <= 1'b1;
      data_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      out_cnt_q    <= out_cnt_d;
      img_q        <= img_d;
      res_q        <= res_d;
      in_ready_q   <= in_ready_d;
      data_valid_q <= data_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign data_valid    = data_valid_q;
  assign InputDataPort = img_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign busy          = busy_q;

`ifdef RBM_ARGMAX_EN
  rbm_argmax #(
    .bitlength  (bitlength),
    .output_dim (output_dim)
  ) u_argmax (
    .result (res_q),
    .argmax (argmax)
  );

  assign argmax_valid = out_valid_q;
`endif

endmodule

// File: tb/tb_rbm_host_if.sv
// Self-checking bench for rbm_host_if (bitlength=12, input_dim=4, output_dim=3):
// directed vector table, hand-written reset/tie sequences, randomized images.
module tb_rbm_host_if;

  localparam int BL = 12;
  localparam int ID = 4;
  localparam int OD = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic [BL-1:0]  in_data = '0;
  logic           in_ready;
  logic           data_valid;
  logic [ID*BL-1:0] InputDataPort;
  logic [OD*BL-1:0] OutputDataPort = '0;
  logic           finish = 1'b0;
  logic           out_valid;
  logic [BL-1:0]  out_data;
  logic           out_last;
  logic           out_ready = 1'b0;
  logic           busy;
`ifdef RBM_ARGMAX_EN
  logic [1:0]     argmax;
  logic           argmax_valid;
`endif

  int total = 0;
  int bad   = 0;

  rbm_host_if #(.bitlength(BL), .input_dim(ID), .output_dim(OD)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .data_valid     (data_valid),
    .InputDataPort  (InputDataPort),
    .OutputDataPort (OutputDataPort),
    .finish         (finish),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .busy           (busy)
`ifdef RBM_ARGMAX_EN
    ,
    .argmax         (argmax),
    .argmax_valid   (argmax_valid)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load4(input logic [ID*BL-1:0] v);
    for (int k = 0; k < ID; k++) begin
      in_valid = 1'b1;
      in_data  = v[k*BL +: BL];
      tick();
    end
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic           iv;
    logic [BL-1:0]  din;
    logic           fin;
    logic           ordy;
    logic           e_ird;
    logic           e_dv;
    logic           e_ov;
    logic [BL-1:0]  e_od;
    logic           e_ol;
    logic           e_busy;
    logic [ID*BL-1:0] e_img;
  } vec_t;

  vec_t tbl [13];

  logic [BL-1:0]    pix_m [ID];
  logic [BL-1:0]    res_m [OD];
  logic [ID*BL-1:0] exp_img;
  int               best;
  int               sent, idx, cyc;
  logic             hs;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //             iv   din      fin   ordy  ird   dv    ov    od       ol    busy  img
    tbl[0]  = '{1'b1, 12'h001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 48'h000000000001};
    tbl[1]  = '{1'b1, 12'h002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 48'h000000002001};
    tbl[2]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 48'h000000002001};
    tbl[3]  = '{1'b1, 12'h003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 48'h000003002001};
    tbl[4]  = '{1'b1, 12'h004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 48'h004003002001};
    tbl[5]  = '{1'b1, 12'h0AA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 48'h004003002001};
    tbl[6]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h800, 1'b0, 1'b1, 48'h004003002001};
    tbl[7]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h005, 1'b0, 1'b1, 48'h004003002001};
    tbl[8]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h005, 1'b0, 1'b1, 48'h004003002001};
    tbl[9]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h005, 1'b0, 1'b1, 48'h004003002001};
    tbl[10] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h005, 1'b0, 1'b1, 48'h004003002001};
    tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1, 48'h004003002001};
    tbl[12] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 48'h004003002001};

    // Reset for two cycles.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready",   in_ready,      1);
    chk("rst_data_valid", data_valid,    0);
    chk("rst_out_valid",  out_valid,     0);
    chk("rst_img",        InputDataPort, 0);
    chk("rst_busy",       busy,          0);
    chk("rst_out_data",   out_data,      0);
    chk("rst_out_last",   out_last,      0);

    // Directed image through LOAD, RUN and a back-pressured DRAIN.
    OutputDataPort = {12'h7FF, 12'h005, 12'h800};
    for (int i = 0; i < 13; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].din;
      finish    = tbl[i].fin;
      out_ready = tbl[i].ordy;
      tick();
      chk($sformatf("tbl%0d_in_ready", i),   in_ready,      tbl[i].e_ird);
      chk($sformatf("tbl%0d_data_valid", i), data_valid,    tbl[i].e_dv);
      chk($sformatf("tbl%0d_out_valid", i),  out_valid,     tbl[i].e_ov);
      chk($sformatf("tbl%0d_out_data", i),   out_data,      tbl[i].e_od);
      chk($sformatf("tbl%0d_out_last", i),   out_last,      tbl[i].e_ol);
      chk($sformatf("tbl%0d_busy", i),       busy,          tbl[i].e_busy);
      chk($sformatf("tbl%0d_img", i),        InputDataPort, tbl[i].e_img);
`ifdef RBM_ARGMAX_EN
      if (i >= 6 && i <= 11) begin
        chk($sformatf("tbl%0d_argmax", i),       argmax,       2);
        chk($sformatf("tbl%0d_argmax_valid", i), argmax_valid, 1);
      end else begin
        chk($sformatf("tbl%0d_argmax_valid", i), argmax_valid, 0);
      end
`endif
    end
    in_valid  = 1'b0;
    finish    = 1'b0;
    out_ready = 1'b0;

    // Reset during RUN abandons the image; finish in LOAD is ignored.
    load4(48'h0440330220AB);
    chk("rr_pre_dv", data_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_data_valid", data_valid,    0);
    chk("rr_in_ready",   in_ready,      1);
    chk("rr_out_valid",  out_valid,     0);
    chk("rr_busy",       busy,          0);
    chk("rr_img",        InputDataPort, 0);
    finish    = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("ld_fin%0d_out_valid", c), out_valid, 0);
      chk($sformatf("ld_fin%0d_busy", c),      busy,      0);
      chk($sformatf("ld_fin%0d_in_ready", c),  in_ready,  1);
    end
    finish    = 1'b0;
    out_ready = 1'b0;

    // Reset during DRAIN emits nothing further.
    OutputDataPort = {12'h333, 12'h222, 12'h111};
    load4(48'h000000000000);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("rd_pre_ov", out_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    chk("rd_out_valid", out_valid, 0);
    chk("rd_out_data",  out_data,  0);
    tick();
    chk("rd_out_valid2", out_valid, 0);
    out_ready = 1'b0;

    // Tie on the maximum: lowest index wins; stream order preserved.
    OutputDataPort = {12'h00F, 12'h010, 12'h010};
    load4(48'h123456789ABC);
    chk("tie_img", InputDataPort, 48'h123456789ABC);
    finish = 1'b1;
    tick();
    finish    = 1'b0;
    out_ready = 1'b1;
`ifdef RBM_ARGMAX_EN
    chk("tie_argmax", argmax, 0);
`endif
    chk("tie_e0", out_data, 12'h010);
    tick();
    chk("tie_e1", out_data, 12'h010);
    tick();
    chk("tie_e2", out_data, 12'h00F);
    chk("tie_last", out_last, 1);
    tick();
    chk("tie_done", out_valid, 0);
    out_ready = 1'b0;

    // Randomized images checked against a transaction-level model.
    for (int n = 0; n < 20; n++) begin
      exp_img = '0;
      for (int k = 0; k < ID; k++) begin
        pix_m[k] = BL'($urandom_range(0, 4095));
        exp_img  = exp_img | ((ID*BL)'(pix_m[k]) << (BL * k));
      end
      for (int k = 0; k < OD; k++) res_m[k] = BL'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) == 0) res_m[2] = res_m[0];
      if ($urandom_range(0, 3) == 0) res_m[1] = res_m[2];
      best = 0;
      for (int k = 1; k < OD; k++) begin
        if ($signed(res_m[k]) > $signed(res_m[best])) best = k;
      end
      OutputDataPort = {res_m[2], res_m[1], res_m[0]};

      sent = 0;
      cyc  = 0;
      while (sent < ID && cyc < 200) begin
        chk("rnd_load_in_ready", in_ready, 1);
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = in_valid ? pix_m[sent] : BL'($urandom);
        hs       = in_valid && in_ready;
        tick();
        if (hs) sent++;
        cyc++;
      end
      in_valid = 1'b0;
      chk("rnd_load_budget", (sent == ID), 1);
      chk("rnd_dv",  data_valid,    1);
      chk("rnd_ird", in_ready,      0);
      chk("rnd_img", InputDataPort, exp_img);

      for (int w = $urandom_range(0, 5); w > 0; w--) begin
        in_valid = $urandom_range(0, 1);
        in_data  = BL'($urandom);
        tick();
        chk("rnd_run_dv",  data_valid,    1);
        chk("rnd_run_ird", in_ready,      0);
        chk("rnd_run_img", InputDataPort, exp_img);
      end
      in_valid = 1'b0;
      finish   = 1'b1;
      tick();
      finish = 1'b0;
      chk("rnd_fin_dv", data_valid, 0);
      chk("rnd_fin_ov", out_valid,  1);
`ifdef RBM_ARGMAX_EN
      chk("rnd_argmax", argmax, best);
`endif

      idx = 0;
      cyc = 0;
      while (idx < OD && cyc < 200) begin
        out_ready = $urandom_range(0, 1);
        finish    = $urandom_range(0, 1);
        chk("rnd_ov",   out_valid, 1);
        chk("rnd_od",   out_data,  res_m[idx]);
        chk("rnd_last", out_last,  (idx == OD - 1));
        hs = out_ready;
        tick();
        if (hs) idx++;
        cyc++;
      end
      out_ready = 1'b0;
      finish    = 1'b0;
      chk("rnd_drain_budget", (idx == OD), 1);
      chk("rnd_end_ov",   out_valid, 0);
      chk("rnd_end_ird",  in_ready,  1);
      chk("rnd_end_busy", busy,      0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
